pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/branch handshake bundle between the decode stage and the hazard controller.
// The master side drives the decoded instruction and the branch resolution.
// The slave side returns the pass, PC-advance, flush and stall-count controls.
interface pipeline_hazard_ctrl_if;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        dec_rs1_en;
    logic        dec_rs2_en;
    logic [4:0]  dec_rd;
    logic        dec_rd_en;
    logic        dec_branch;
    logic        br_resolved;
    logic        br_taken;
    logic        d_pass;
    logic        d_pcincr;
    logic        flush;
    logic [15:0] stall_cnt;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rs1_en, dec_rs2_en,
        output dec_rd, dec_rd_en, dec_branch, br_resolved, br_taken,
        input  d_pass, d_pcincr, flush, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rs1_en, dec_rs2_en,
        input  dec_rd, dec_rd_en, dec_branch, br_resolved, br_taken,
        output d_pass, d_pcincr, flush, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: RAW stall via a 3-entry destination scoreboard
// (E, M, R stages) and branch hold/flush until execute resolves the branch.
// Optional stall-cycle counter enabled by defining HAZARD_CTRL_STALL_CNT_EN.
module pipeline_hazard_ctrl (
    input  logic                         clk,
    input  logic                         rst,
    pipeline_hazard_ctrl_if.slave        hz
);
    typedef enum logic {RUN, BR_WAIT} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_sb_valid;
    logic [4:0]  r_sb_rd [3];
    logic        w_sb0_valid;
    logic        w_hazard;
    logic        w_rs1_hit;
    logic        w_rs2_hit;
    logic        w_pass;
    logic        w_pcincr;
    logic        w_flush;

    // Source-vs-scoreboard compare; register 0 never creates a dependency.
    always_comb begin
        w_rs1_hit = 1'b0;
        w_rs2_hit = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (r_sb_valid[k] && (r_sb_rd[k] == hz.dec_rs1)) w_rs1_hit = 1'b1;
            if (r_sb_valid[k] && (r_sb_rd[k] == hz.dec_rs2)) w_rs2_hit = 1'b1;
        end
        w_hazard = hz.dec_valid &&
                   ((hz.dec_rs1_en && (hz.dec_rs1 != 5'd0) && w_rs1_hit) ||
                    (hz.dec_rs2_en && (hz.dec_rs2 != 5'd0) && w_rs2_hit));
    end

    // Next-state and zero-latency control outputs; reset forces the idle-advance pattern.
    always_comb begin
        w_next_state = r_state;
        w_pass       = 1'b0;
        w_pcincr     = 1'b1;
        w_flush      = 1'b0;
        w_sb0_valid  = 1'b0;
        if (rst) begin
            case (r_state)
                RUN: begin
                    if (hz.dec_valid) begin
                        if (w_hazard) begin
                            w_pcincr = 1'b0;
                        end else begin
                            w_pass      = 1'b1;
                            w_sb0_valid = hz.dec_rd_en && (hz.dec_rd != 5'd0);
                            if (hz.dec_branch) w_next_state = BR_WAIT;
                        end
                    end
                end
                BR_WAIT: begin
                    if (hz.br_resolved) begin
                        w_flush      = hz.br_taken;
                        w_next_state = RUN;
                    end else begin
                        w_pcincr = 1'b0;
                    end
                end
                default: w_next_state = RUN;
            endcase
        end
    end

    // State register and scoreboard shift; sb[2] falls off the end.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= RUN;
            r_sb_valid <= '0;
            r_sb_rd[0] <= '0;
            r_sb_rd[1] <= '0;
            r_sb_rd[2] <= '0;
        end else begin
            r_state    <= w_next_state;
            r_sb_valid <= {r_sb_valid[1:0], w_sb0_valid};
            r_sb_rd[0] <= hz.dec_rd;
            r_sb_rd[1] <= r_sb_rd[0];
            r_sb_rd[2] <= r_sb_rd[1];
        end
    end

    assign hz.d_pass   = w_pass;
    assign hz.d_pcincr = w_pcincr;
    assign hz.flush    = w_flush;

`ifdef HAZARD_CTRL_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (!w_pcincr && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
`else
    assign hz.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-history reference model.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pipeline_hazard_ctrl_if hz_if ();

    pipeline_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cycle of the most recent write to each register,
    // plus a flag for "waiting on a branch".
    int m_last [32];
    int m_cycle;
    int m_cnt;
    bit m_br_wait;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, m_cycle);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_last[i] = -100;
        m_br_wait = 1'b0;
        m_cnt     = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs,
    // then advance the model across the rising edge.
    task automatic step(input bit rstn, input bit vld,
                        input bit [4:0] rs1, input bit rs1en,
                        input bit [4:0] rs2, input bit rs2en,
                        input bit [4:0] rd, input bit rden, input bit br,
                        input bit brres, input bit brtk);
        bit haz, e_pass, e_pc, e_fl;
        @(negedge clk);
        rst                = rstn;
        hz_if.dec_valid    = vld;
        hz_if.dec_rs1      = rs1;
        hz_if.dec_rs1_en   = rs1en;
        hz_if.dec_rs2      = rs2;
        hz_if.dec_rs2_en   = rs2en;
        hz_if.dec_rd       = rd;
        hz_if.dec_rd_en    = rden;
        hz_if.dec_branch   = br;
        hz_if.br_resolved  = brres;
        hz_if.br_taken     = brtk;
        #2;
        haz = (rs1en && rs1 != 0 && (m_cycle - m_last[rs1]) <= 3) ||
              (rs2en && rs2 != 0 && (m_cycle - m_last[rs2]) <= 3);
        if (!rstn) begin
            e_pass = 0; e_pc = 1; e_fl = 0;
        end else if (m_br_wait) begin
            e_pass = 0; e_pc = brres; e_fl = brres && brtk;
        end else if (!vld) begin
            e_pass = 0; e_pc = 1; e_fl = 0;
        end else begin
            e_pass = !haz; e_pc = !haz; e_fl = 0;
        end
        chk("d_pass",    {15'd0, hz_if.d_pass},   {15'd0, e_pass});
        chk("d_pcincr",  {15'd0, hz_if.d_pcincr}, {15'd0, e_pc});
        chk("flush",     {15'd0, hz_if.flush},    {15'd0, e_fl});
        chk("stall_cnt", hz_if.stall_cnt,         m_cnt[15:0]);
        @(posedge clk);
        if (!rstn) begin
            model_reset();
        end else begin
`ifdef HAZARD_CTRL_STALL_CNT_EN
            if (!e_pc && m_cnt < 65535) m_cnt++;
`endif
            if (m_br_wait) begin
                if (brres) m_br_wait = 1'b0;
            end else if (vld && !haz) begin
                if (rden && rd != 0) m_last[rd] = m_cycle;
                if (br) m_br_wait = 1'b1;
            end
        end
        m_cycle++;
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        m_cycle = 0;
        model_reset();

        // Reset with noisy inputs: outputs must be the reset pattern.
        step(0, 1, 5'd3, 1, 5'd4, 1, 5'd3, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // RAW stall on r5: three held cycles then issue.
        step(1, 1, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 5'd5, 1, 0, 0, 5'd6, 1, 0, 0, 0);
            chk("raw_stall_pcincr", {15'd0, hz_if.d_pcincr}, 16'd0);
        end
        @(negedge clk);
        #2;
        chk("raw_issue_pass", {15'd0, hz_if.d_pass}, 16'd1);
        step(1, 1, 5'd5, 1, 0, 0, 5'd6, 1, 0, 0, 0);
`ifdef HAZARD_CTRL_STALL_CNT_EN
        chk("stall_cnt_after_raw", hz_if.stall_cnt, 16'd3);
`else
        chk("stall_cnt_after_raw", hz_if.stall_cnt, 16'd0);
`endif
        idle(); idle(); idle();

        // r0 is never a dependency.
        step(1, 1, 0, 0, 0, 0, 5'd0, 1, 0, 0, 0);
        step(1, 1, 5'd0, 1, 5'd0, 1, 5'd7, 1, 0, 0, 0);
        idle(); idle(); idle();

        // Taken branch: two waits, then resolve with flush.
        step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Not-taken branch.
        step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Reset while waiting on a branch, with a pending producer of r9.
        step(1, 1, 0, 0, 0, 0, 5'd9, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 1, 5'd9, 1, 0, 0, 0, 0, 0, 1, 1);
        chk("post_reset_cnt", hz_if.stall_cnt, 16'd0);

        // Random traffic over a small register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) == 0), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
